// File: rtl/regfile_alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_alu_sequencer: multi-cycle controller for RegisterFile + ALU     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] ra1,
  output logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              we3,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              result_zero
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] c_kind_ri  = 2'b01;
  localparam logic [1:0] c_kind_li  = 2'b10;
  localparam logic [1:0] c_kind_cmp = 2'b11;

  state_t              r_state;
  logic [1:0]          r_kind;
  logic [OP_W-1:0]     r_op;
  logic [ADDR_W-1:0]   r_rd;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_val;
  logic                r_zero;

  // All datapath-facing outputs are registers so they hold outside their own state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_kind      <= '0;
      r_op        <= '0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_val       <= '0;
      r_zero      <= 1'b0;
      cmd_ready   <= 1'b0;
      ra1         <= '0;
      ra2         <= '0;
      wa3         <= '0;
      wd3         <= '0;
      we3         <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      result_zero <= 1'b0;
    end else begin
      we3  <= 1'b0;
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          // First cycle out of reset only raises ready; accepting needs ready seen high.
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            r_kind    <= cmd_kind;
            r_op      <= cmd_op;
            r_rd      <= cmd_rd;
            r_imm     <= cmd_imm;
            if (cmd_kind == c_kind_li) begin
              wa3     <= cmd_rd;
              wd3     <= cmd_imm;
              we3     <= 1'b1;
              r_val   <= cmd_imm;
              r_zero  <= (cmd_imm == '0);
              r_state <= WRITE;
            end else begin
              ra1     <= cmd_ra;
              ra2     <= cmd_rb;
              r_state <= READ;
            end
          end
        end
        READ: begin
          alu_a    <= rd1;
          alu_b    <= (r_kind == c_kind_ri) ? r_imm : rd2;
          alu_ctrl <= r_op;
          r_state  <= EXEC;
        end
        EXEC: begin
          r_val  <= alu_result;
          r_zero <= alu_zero;
          if (r_kind == c_kind_cmp) begin
            done        <= 1'b1;
            result      <= alu_result;
            result_zero <= alu_zero;
            r_state     <= DONE;
          end else begin
            wa3     <= r_rd;
            wd3     <= alu_result;
            we3     <= 1'b1;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          done        <= 1'b1;
          result      <= r_val;
          result_zero <= r_zero;
          r_state     <= DONE;
        end
        DONE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          r_state   <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
